// File: rtl/lut_prog_pkg.sv
// Shared definitions for the runtime-programmable LUT neuron.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lut_prog_pkg;

  // Loader / lookup state of one neuron table.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } lut_state_t;

  // Number of table entries for a given address width.
  function automatic int depth(input int in_bits);
    return 1 << in_bits;
  endfunction

endpackage

// File: rtl/lut_prog_ram.sv
// Neuron truth-table storage: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; the caller guarantees reads and writes never overlap.
module lut_prog_ram
  import lut_prog_pkg::*;
#(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int DEPTH = depth(ADDR_BITS);

  // Small table: keep it in LUT fabric so the read is asynchronous.
  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [DATA_BITS-1:0] mem [DEPTH];

  // Table write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_prog.sv
// LogicNets neuron whose truth table is streamed in at runtime, then looked up per cycle.
// Latency: lookup result registered 1 cycle after acceptance; table load takes one cycle per entry.
// Backpressure: in_ready drops while a result stalls on out_ready or while no complete table exists.
module lut_neuron_prog
  import lut_prog_pkg::*;
#(
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_last,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                loaded,
  output logic                err
);

  localparam int DEPTH = depth(IN_BITS);
  // Address counter is one bit wider than the table so the final entry is explicit.
  localparam logic [IN_BITS:0] LAST_ADDR = (IN_BITS+1)'(DEPTH - 1);
  localparam logic [IN_BITS:0] ADDR_ONE  = (IN_BITS+1)'(1);

  lut_state_t           state;
  lut_state_t           state_nxt;
  logic [IN_BITS:0]     addr;
  logic                 wr_en;
  logic                 final_entry;
  logic                 accept;
  logic [OUT_BITS-1:0]  rd_data;

  // Next-state logic, loader handshake and write strobe.
  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    cfg_ready   = 1'b0;
    final_entry = (addr == LAST_ADDR);
    case (state)
      EMPTY: begin
        if (cfg_start) state_nxt = LOAD;
      end
      LOAD: begin
        cfg_ready = 1'b1;
        // A restart pulse takes priority; the coincident entry is dropped.
        if (!cfg_start && cfg_valid) begin
          wr_en = 1'b1;
          if (final_entry) begin
            state_nxt = cfg_last ? READY : EMPTY;
          end else if (cfg_last) begin
            state_nxt = EMPTY;
          end
        end
      end
      READY: begin
        if (cfg_start) state_nxt = LOAD;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State register, load address counter and framing status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      addr   <= '0;
      loaded <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cfg_start) begin
        addr   <= '0;
        err    <= 1'b0;
        loaded <= 1'b0;
      end else if (wr_en) begin
        if (final_entry) begin
          addr <= '0;
          if (cfg_last) loaded <= 1'b1;
          else          err    <= 1'b1;
        end else begin
          addr <= addr + ADDR_ONE;
          if (cfg_last) err <= 1'b1;
        end
      end
    end
  end

  assign in_ready = (state == READY) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  lut_prog_ram #(
    .ADDR_BITS (IN_BITS),
    .DATA_BITS (OUT_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (addr[IN_BITS-1:0]),
    .wdata (cfg_data),
    .raddr (in_data),
    .rdata (rd_data)
  );

  // One-entry output register; holds its result until downstream takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= rd_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Directed bench for the programmable LUT neuron: load framing, lookups, stalls, reset, reload.
// Latency: checks results one cycle after lookup acceptance.
// Backpressure: exercises out_ready stalls during lookups and during a reload.
module tb_lut_neuron_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_data;
  logic       cfg_last;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic       loaded;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [1:0] tbl [16];

  always #5 clk = ~clk;

  lut_neuron_prog #(
    .IN_BITS  (4),
    .OUT_BITS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .loaded    (loaded),
    .err       (err)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream tbl[0..stop_at] after a start pulse; cfg_last on entry last_at.
  task automatic load(input int last_at, input int stop_at, input bit toggle, input bit watch);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 0; i <= stop_at; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = tbl[i[3:0]];
      cfg_last  = (i == last_at);
      step();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      if (watch && i < 15) begin
        check("load_in_ready", 8'(in_ready), 8'd0);
        check("load_loaded", 8'(loaded), 8'd0);
        check("load_cfg_ready", 8'(cfg_ready), 8'd1);
      end
      if (toggle && i < stop_at) step();
    end
  endtask

  task automatic lookup(input logic [3:0] a, input logic [1:0] exp, input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = a;
    check({tag, "_in_ready"}, 8'(in_ready), 8'd1);
    step();
    in_valid = 1'b0;
    check({tag, "_out_valid"}, 8'(out_valid), 8'd1);
    check({tag, "_out_data"}, 8'(out_data), 8'(exp));
    step();
    check({tag, "_drained"}, 8'(out_valid), 8'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 2'b00; cfg_last = 1'b0;
    in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    step();
    step();
    check("rst_cfg_ready", 8'(cfg_ready), 8'd0);
    check("rst_in_ready", 8'(in_ready), 8'd0);
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_out_data", 8'(out_data), 8'd0);
    check("rst_loaded", 8'(loaded), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    rst = 1'b0;
    step();
    check("empty_cfg_ready", 8'(cfg_ready), 8'd0);

    // Test 1: fifteen zeros then 01 at the last entry.
    for (int i = 0; i < 16; i++) tbl[i] = 2'b00;
    tbl[15] = 2'b01;
    load(15, 15, 1'b0, 1'b0);
    check("t1_loaded", 8'(loaded), 8'd1);
    check("t1_err", 8'(err), 8'd0);
    check("t1_cfg_ready", 8'(cfg_ready), 8'd0);
    lookup(4'hF, 2'b01, "t1_f");
    lookup(4'hE, 2'b00, "t1_e");

    // Test 2: gapped load, entry i = i mod 4.
    for (int i = 0; i < 16; i++) tbl[i] = 2'(i);
    load(15, 15, 1'b1, 1'b1);
    check("t2_loaded", 8'(loaded), 8'd1);
    lookup(4'h6, 2'b10, "t2_6");
    lookup(4'hB, 2'b11, "t2_b");
    lookup(4'h1, 2'b01, "t2_1");

    // Test 3: early cfg_last, then a clean reload. Entry i = (3 - i) mod 4.
    for (int i = 0; i < 16; i++) tbl[i] = 2'(3 - i);
    load(7, 7, 1'b0, 1'b0);
    check("t3_err", 8'(err), 8'd1);
    check("t3_loaded", 8'(loaded), 8'd0);
    check("t3_in_ready", 8'(in_ready), 8'd0);
    check("t3_cfg_ready", 8'(cfg_ready), 8'd0);
    step();
    check("t3_err_sticky", 8'(err), 8'd1);
    load(15, 15, 1'b0, 1'b0);
    check("t3_reload_err", 8'(err), 8'd0);
    check("t3_reload_loaded", 8'(loaded), 8'd1);
    lookup(4'h0, 2'b11, "t3_0");
    lookup(4'hE, 2'b01, "t3_e");

    // Test 4: stall with in_valid held, then back-to-back.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'h2;
    step();
    check("t4_first_valid", 8'(out_valid), 8'd1);
    check("t4_first_data", 8'(out_data), 8'h1);
    check("t4_stall_in_ready", 8'(in_ready), 8'd0);
    in_data = 4'h5;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_hold_data", 8'(out_data), 8'h1);
      check("t4_hold_in_ready", 8'(in_ready), 8'd0);
    end
    out_ready = 1'b1;
    #1;
    check("t4_release_in_ready", 8'(in_ready), 8'd1);
    step();
    check("t4_b2b_5", 8'(out_data), 8'h2);
    in_data = 4'h8;
    step();
    check("t4_b2b_8", 8'(out_data), 8'h3);
    in_data = 4'hF;
    step();
    check("t4_b2b_f", 8'(out_data), 8'h0);
    in_data = 4'h4;
    step();
    check("t4_b2b_4", 8'(out_data), 8'h3);
    check("t4_b2b_valid", 8'(out_valid), 8'd1);
    in_valid = 1'b0;
    step();
    check("t4_drained", 8'(out_valid), 8'd0);

    // Test 5: asynchronous reset after entry 5 of a load.
    for (int i = 0; i < 16; i++) tbl[i] = 2'b00;
    tbl[15] = 2'b01;
    load(15, 5, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_cfg_ready", 8'(cfg_ready), 8'd0);
    check("t5_in_ready", 8'(in_ready), 8'd0);
    check("t5_out_valid", 8'(out_valid), 8'd0);
    check("t5_out_data", 8'(out_data), 8'd0);
    check("t5_loaded", 8'(loaded), 8'd0);
    check("t5_err", 8'(err), 8'd0);
    #2;
    rst = 1'b0;
    step();
    load(15, 15, 1'b0, 1'b0);
    check("t5_loaded_after", 8'(loaded), 8'd1);
    lookup(4'hF, 2'b01, "t5_f");
    lookup(4'hE, 2'b00, "t5_e");

    // Test 6: reload an inverted table while a result is stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'hF;
    step();
    in_valid = 1'b0;
    check("t6_stall_data", 8'(out_data), 8'h1);
    for (int i = 0; i < 16; i++) tbl[i] = 2'b11;
    tbl[15] = 2'b10;
    load(15, 15, 1'b0, 1'b0);
    check("t6_kept_valid", 8'(out_valid), 8'd1);
    check("t6_kept_data", 8'(out_data), 8'h1);
    check("t6_loaded", 8'(loaded), 8'd1);
    out_ready = 1'b1;
    step();
    check("t6_drained", 8'(out_valid), 8'd0);
    lookup(4'hF, 2'b10, "t6_f");
    lookup(4'h3, 2'b11, "t6_3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
